// File: rtl/joyport_arbiter.sv
// Shares MSX joystick port A between the digital joystick and the PS/2 mouse adapter.
// Source selection is activity driven, debounced, rate limited, and never cuts a mouse nibble read.
module joyport_arbiter #(
  parameter int DEBOUNCE = 16,
  parameter int QUIET    = 256,
  parameter int IDLE_TMO = 2**24,
  parameter int LOCKOUT  = 4096
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic [5:0] joy_in,
  input  logic       mouse_act,
  input  logic [5:0] mouse_data,
  input  logic       port_str,
  output logic [5:0] port_data,
  output logic       mouse_str,
  output logic       mouse_mode
);

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int QW = $clog2(QUIET + 1);
  localparam int IW = $clog2(IDLE_TMO + 1);
  localparam int LW = $clog2(LOCKOUT + 1);

  localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE);
  localparam logic [QW-1:0] QUIET_MAX = QW'(QUIET);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_TMO);
  localparam logic [LW-1:0] LOCK_MAX  = LW'(LOCKOUT);

  typedef enum logic [1:0] {
    S_JOY   = 2'd0,
    S_MOUSE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [DW-1:0] r_deb,   w_deb_nxt;
  logic [QW-1:0] r_quiet, w_quiet_nxt;
  logic [IW-1:0] r_idle,  w_idle_nxt;
  logic [LW-1:0] r_lock,  w_lock_nxt;
  logic          r_drain_joy, w_drain_joy_nxt;
  logic          r_str_d;
  logic [5:0]    r_port;
  logic          r_mstr;
  logic          w_commit;
  logic          w_str_edge;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_str_edge = port_str ^ r_str_d;

    w_deb_nxt = r_deb;
    if (joy_in == 6'd0)        w_deb_nxt = '0;
    else if (r_deb != DEB_MAX) w_deb_nxt = r_deb + 1'b1;

    w_idle_nxt = r_idle;
    if (r_state == S_JOY || mouse_act) w_idle_nxt = '0;
    else if (r_idle != IDLE_MAX)       w_idle_nxt = r_idle + 1'b1;

    w_quiet_nxt = r_quiet;
    if (w_str_edge)                w_quiet_nxt = '0;
    else if (r_quiet != QUIET_MAX) w_quiet_nxt = r_quiet + 1'b1;

    // Thresholds are taken on the counters' next values, so a switch lands on the cycle the count is reached.
    w_state_nxt     = r_state;
    w_drain_joy_nxt = r_drain_joy;
    w_commit        = 1'b0;
    case (r_state)
      S_JOY: begin
        if (mouse_act && r_lock == '0) begin
          w_state_nxt = S_MOUSE;
          w_commit    = 1'b1;
        end
      end
      S_MOUSE: begin
        if (r_lock == '0) begin
          if (w_deb_nxt == DEB_MAX) begin
            w_state_nxt     = S_DRAIN;
            w_drain_joy_nxt = 1'b1;
          end else if (w_idle_nxt == IDLE_MAX) begin
            w_state_nxt     = S_DRAIN;
            w_drain_joy_nxt = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        // Mouse activity always beats the pending return so a running nibble read is never cut.
        if (mouse_act || (r_drain_joy && joy_in == 6'd0)) begin
          w_state_nxt = S_MOUSE;
        end else if (w_quiet_nxt == QUIET_MAX) begin
          w_state_nxt = S_JOY;
          w_commit    = 1'b1;
        end
      end
      default: w_state_nxt = S_JOY;
    endcase

    w_lock_nxt = r_lock;
    if (w_commit)            w_lock_nxt = LOCK_MAX;
    else if (r_lock != '0)   w_lock_nxt = r_lock - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_JOY;
      r_deb       <= '0;
      r_quiet     <= '0;
      r_idle      <= '0;
      r_lock      <= '0;
      r_drain_joy <= 1'b0;
      r_str_d     <= 1'b0;
      r_port      <= 6'h3F;
      r_mstr      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_deb       <= w_deb_nxt;
      r_idle      <= w_idle_nxt;
      r_lock      <= w_lock_nxt;
      r_drain_joy <= w_drain_joy_nxt;
      r_str_d     <= port_str;
      r_quiet     <= (r_state == S_DRAIN && w_state_nxt == S_DRAIN) ? w_quiet_nxt : '0;
      // The port source follows the next state so data and mouse_mode change on the same edge.
      r_port      <= (w_state_nxt == S_JOY) ? ~joy_in : mouse_data;
      if (w_state_nxt != S_JOY) r_mstr <= port_str;
    end
  end

  assign port_data  = r_port;
  assign mouse_str  = r_mstr;
  assign mouse_mode = (r_state != S_JOY);

endmodule

// File: tb/tb_joyport_arbiter.sv
// Directed self-checking bench for joyport_arbiter (IDLE_TMO shortened to 1000).
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_joyport_arbiter;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic [5:0] joy_in;
  logic       mouse_act;
  logic [5:0] mouse_data;
  logic       port_str;
  logic [5:0] port_data;
  logic       mouse_str;
  logic       mouse_mode;

  int n_tests = 0;
  int n_fail  = 0;

  joyport_arbiter #(
    .DEBOUNCE(16),
    .QUIET   (256),
    .IDLE_TMO(1000),
    .LOCKOUT (4096)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .joy_in    (joy_in),
    .mouse_act (mouse_act),
    .mouse_data(mouse_data),
    .port_str  (port_str),
    .port_data (port_data),
    .mouse_str (mouse_str),
    .mouse_mode(mouse_mode)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic steps(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs n cycles in MOUSE with a mouse_act pulse every 200 cycles so the idle timeout never fires.
  task automatic keepalive(input int n);
    for (int i = 0; i < n; i++) begin
      mouse_act = (i % 200 == 0);
      steps(1);
    end
    mouse_act = 1'b0;
  endtask

  initial begin
    // 1. Reset behaviour and joystick pass-through
    reset_n = 1'b0; joy_in = 6'h01; mouse_act = 1'b0; mouse_data = 6'h3F; port_str = 1'b0;
    steps(3);
    check("rst_port", port_data, 6'h3F);
    check("rst_mode", {5'd0, mouse_mode}, 6'd0);
    check("rst_mstr", {5'd0, mouse_str}, 6'd0);
    reset_n = 1'b1;
    steps(2);
    check("rel_port", port_data, 6'h3E);
    joy_in = 6'h2D;
    steps(1);
    check("joy_2d", port_data, 6'h12);
    joy_in = 6'h00;
    steps(1);
    check("joy_00", port_data, 6'h3F);

    // 2. Mouse takes the port; registered data and strobe
    mouse_data = 6'h2A; mouse_act = 1'b1;
    check("pre_entry_mode", {5'd0, mouse_mode}, 6'd0);
    steps(1);
    mouse_act = 1'b0;
    check("entry_mode", {5'd0, mouse_mode}, 6'd1);
    check("entry_port", port_data, 6'h2A);
    port_str = 1'b1;
    check("str_no_comb", {5'd0, mouse_str}, 6'd0);
    steps(1);
    check("str_rise", {5'd0, mouse_str}, 6'd1);
    port_str = 1'b0;
    steps(1);
    check("str_fall", {5'd0, mouse_str}, 6'd0);
    mouse_data = 6'h15;
    steps(1);
    check("mdata_15", port_data, 6'h15);
    keepalive(4200);

    // 4. Fifteen cycles of joystick is one short of the debounce threshold
    mouse_act = 1'b1; steps(1); mouse_act = 1'b0;
    joy_in = 6'h10; steps(15);
    joy_in = 6'h00; steps(1);
    check("deb15_mode", {5'd0, mouse_mode}, 6'd1);
    check("deb15_port", port_data, 6'h15);

    // 3a. Hold 16 cycles without strobe edges: DRAIN on the 16th edge, JOY 256 edges later
    mouse_act = 1'b1; steps(1); mouse_act = 1'b0;
    joy_in = 6'h10;
    steps(271);
    check("deb_quiet_pre", {5'd0, mouse_mode}, 6'd1);
    steps(1);
    check("deb_quiet_joy", {5'd0, mouse_mode}, 6'd0);
    check("deb_quiet_port", port_data, 6'h2F);

    // 6a. mouse_act inside the lockout window is ignored; accepted once it expires
    joy_in = 6'h00;
    steps(9);
    mouse_act = 1'b1; steps(1); mouse_act = 1'b0;
    check("lock_early_mode", {5'd0, mouse_mode}, 6'd0);
    check("lock_early_port", port_data, 6'h3F);
    steps(4085);
    mouse_act = 1'b1;
    steps(1);
    check("lock_last_mode", {5'd0, mouse_mode}, 6'd0);
    steps(1);
    mouse_act = 1'b0;
    check("lock_expired_mode", {5'd0, mouse_mode}, 6'd1);
    port_str = 1'b1;
    keepalive(4200);

    // Joystick-triggered drain aborts when the stick is released
    mouse_act = 1'b1; steps(1); mouse_act = 1'b0;
    joy_in = 6'h10; steps(66);
    joy_in = 6'h00; steps(301);
    check("joy_abort_mode", {5'd0, mouse_mode}, 6'd1);

    // 3b. Strobe edges every 100 cycles hold off the switch; JOY 256 edges after the last one
    mouse_act = 1'b1; steps(1); mouse_act = 1'b0;
    joy_in = 6'h10; steps(16);
    for (int k = 0; k < 3; k++) begin
      port_str = ~port_str;
      steps(100);
      check("toggle_mode", {5'd0, mouse_mode}, 6'd1);
      check("toggle_mstr", {5'd0, mouse_str}, {5'd0, port_str});
    end
    port_str = ~port_str;
    steps(256);
    check("last_edge_pre", {5'd0, mouse_mode}, 6'd1);
    steps(1);
    check("last_edge_joy", {5'd0, mouse_mode}, 6'd0);
    check("last_edge_port", port_data, 6'h2F);

    // 5a. Idle timeout: DRAIN 1000 cycles after the last mouse_act, JOY after QUIET more
    joy_in = 6'h00;
    steps(4100);
    mouse_act = 1'b1; steps(1); mouse_act = 1'b0;
    check("reentry1_mode", {5'd0, mouse_mode}, 6'd1);
    keepalive(4200);
    mouse_act = 1'b1; steps(1); mouse_act = 1'b0;
    steps(1255);
    check("idle_pre", {5'd0, mouse_mode}, 6'd1);
    steps(1);
    check("idle_joy", {5'd0, mouse_mode}, 6'd0);
    check("idle_port", port_data, 6'h3F);

    // 5b. mouse_act inside an idle drain returns to MOUSE; 6b. reset mid-DRAIN
    steps(4100);
    mouse_data = 6'h2A;
    mouse_act = 1'b1; steps(1); mouse_act = 1'b0;
    keepalive(4200);
    mouse_act = 1'b1; steps(1); mouse_act = 1'b0;
    steps(1100);
    mouse_act = 1'b1; steps(1); mouse_act = 1'b0;
    steps(300);
    check("drain_abort_mode", {5'd0, mouse_mode}, 6'd1);
    steps(800);
    check("drain2_mode", {5'd0, mouse_mode}, 6'd1);
    check("drain2_port", port_data, 6'h2A);
    check("drain2_mstr", {5'd0, mouse_str}, 6'd1);
    reset_n = 1'b0;
    #1;
    check("async_rst_mode", {5'd0, mouse_mode}, 6'd0);
    check("async_rst_port", port_data, 6'h3F);
    check("async_rst_mstr", {5'd0, mouse_str}, 6'd0);
    steps(2);
    reset_n = 1'b1;
    steps(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
